fixed_mac_lanes: RTL and testbench

FIXED_MAC_LANES -- requirements
Module: fixed_mac_lanes

---
 rtl/fixed_mac_lanes.sv | 201 ++++++++++++++++++++
 tb/tb_fixed_mac_lanes.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mac_lanes.sv
`default_nettype none
// ============================================================================
// Module   : fixed_mac_lanes
// Brief    : Multi-lane signed fixed-point packet dot-product. Stage P
//            registers per-lane products, stage A folds them into a wide
//            accumulator, and each closing beat is converted, rounded or
//            truncated, saturated or wrapped, then held in a single-entry
//            output register.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_mac_lanes #(
    parameter int WI1   = 6,
    parameter int WF1   = 10,
    parameter int WI2   = 4,
    parameter int WF2   = 8,
    parameter int WIO   = 15,
    parameter int WFO   = 30,
    parameter int LANES = 4,
    parameter int GUARD = 8,
    parameter int SAT   = 1,
    parameter int ROUND = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LANES*(WI1+WF1)-1:0]     A_data,
    input  logic                           A_valid,
    output logic                           A_ready,
    input  logic                           A_last,
    input  logic [LANES*(WI2+WF2)-1:0]     B_data,
    input  logic                           B_valid,
    output logic                           B_ready,
    input  logic                           B_last,
    output logic [WIO+WFO-1:0]             out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_ovf,
    output logic                           out_mismatch
);

    localparam int c_AW    = WI1 + WF1;
    localparam int c_BW    = WI2 + WF2;
    localparam int c_FP    = WF1 + WF2;
    localparam int c_PW    = WI1 + WI2 + c_FP;
    localparam int c_ACC_W = WI1 + WI2 + $clog2(LANES) + GUARD + c_FP;
    localparam int c_OW    = WIO + WFO;
    localparam int c_SHL   = (WFO >= c_FP) ? (WFO - c_FP) : 0;
    localparam int c_SHR   = (WFO <  c_FP) ? (c_FP - WFO) : 0;
    // One spare bit above the scaled value so the half-LSB rounding add
    // cannot overflow, and always at least one bit above the output width
    // so the overflow test has a sign-extension slice to inspect.
    localparam int c_EXT_A = c_ACC_W + c_SHL + 1;
    localparam int c_EXT_W = (c_EXT_A > c_OW + 1) ? c_EXT_A : (c_OW + 1);
    localparam int c_HW    = c_EXT_W - c_OW + 1;

    logic                      r_run;
    logic                      r_p_valid;
    logic                      r_p_last;
    logic                      r_p_mis;
    logic signed [c_PW-1:0]    r_p_prod [LANES];
    logic signed [c_ACC_W-1:0] r_acc;
    logic                      r_o_valid;
    logic [c_OW-1:0]           r_o_data;
    logic                      r_o_ovf;
    logic                      r_o_mis;

    logic signed [c_PW-1:0]    w_prod [LANES];
    logic signed [c_ACC_W-1:0] w_tree;
    logic signed [c_ACC_W-1:0] w_final;
    logic signed [c_EXT_W-1:0] w_ext;
    logic signed [c_EXT_W-1:0] w_scaled;
    logic [c_HW-1:0]           w_hi;
    logic                      w_ovf;
    logic [c_OW-1:0]           w_conv;
    logic                      w_p_adv;
    logic                      w_ready;
    logic                      w_fire;
    logic                      w_close;
    logic                      w_drain;

    // Per-lane signed products, operands sign-extended to the product width.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [c_AW-1:0] w_a;
        logic signed [c_BW-1:0] w_b;
        assign w_a       = A_data[i*c_AW +: c_AW];
        assign w_b       = B_data[i*c_BW +: c_BW];
        assign w_prod[i] = c_PW'(w_a) * c_PW'(w_b);
    end

    // Handshake: ready depends only on pipeline occupancy, never on valid.
    assign w_drain = r_o_valid & out_ready;
    assign w_p_adv = ~r_p_valid | ~r_p_last | ~r_o_valid | out_ready;
    assign w_ready = r_run & w_p_adv;
    assign w_fire  = A_valid & B_valid & w_ready;
    assign w_close = r_p_valid & r_p_last & w_p_adv;

    assign A_ready = w_ready;
    assign B_ready = w_ready;

    // Lane-sum tree over the registered products, widened to the accumulator.
    always_comb begin
        w_tree = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree = w_tree + c_ACC_W'(r_p_prod[i]);
        end
    end

    assign w_final = r_acc + w_tree;
    assign w_ext   = c_EXT_W'(w_final);

    // Align the binary point of the packet sum to the output format.
    if (c_SHR > 0) begin : g_shr
        if (ROUND != 0) begin : g_round
            localparam logic signed [c_EXT_W-1:0] c_HALF = c_EXT_W'(1) << (c_SHR - 1);
            assign w_scaled = (w_ext + c_HALF) >>> c_SHR;
        end else begin : g_trunc
            assign w_scaled = w_ext >>> c_SHR;
        end
    end else begin : g_shl
        assign w_scaled = w_ext <<< c_SHL;
    end

    // The value fits iff every bit from the output sign bit upward agrees.
    assign w_hi  = w_scaled[c_EXT_W-1:c_OW-1];
    assign w_ovf = ~((&w_hi) | ~(|w_hi));

    // Clamp to the extreme of the right sign, or keep the low bits to wrap.
    always_comb begin
        w_conv = w_scaled[c_OW-1:0];
        if (w_ovf && (SAT != 0)) begin
            w_conv = w_scaled[c_EXT_W-1] ? {1'b1, {(c_OW-1){1'b0}}}
                                         : {1'b0, {(c_OW-1){1'b1}}};
        end
    end

    // Ready stays low until the first clock edge after reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Stage P: capture lane products and closing/mismatch flags of each beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_mis   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_p_prod[i] <= '0;
            end
        end else if (w_p_adv) begin
            r_p_valid <= w_fire;
            if (w_fire) begin
                r_p_last <= A_last | B_last;
                r_p_mis  <= A_last ^ B_last;
                for (int i = 0; i < LANES; i++) begin
                    r_p_prod[i] <= w_prod[i];
                end
            end
        end
    end

    // Stage A: fold non-closing beats, restart from zero once a packet closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (r_p_valid && w_p_adv) begin
            if (r_p_last) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_final;
            end
        end
    end

    // Single-entry output register, held until the downstream accepts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_ovf   <= 1'b0;
            r_o_mis   <= 1'b0;
        end else if (w_close) begin
            r_o_valid <= 1'b1;
            r_o_data  <= w_conv;
            r_o_ovf   <= w_ovf;
            r_o_mis   <= r_p_mis;
        end else if (w_drain) begin
            r_o_valid <= 1'b0;
        end
    end

    assign out_valid    = r_o_valid;
    assign out_data     = r_o_data;
    assign out_ovf      = r_o_ovf;
    assign out_mismatch = r_o_mis;

endmodule
`default_nettype wire

// File: tb/tb_fixed_mac_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_mac_lanes
// Brief    : Self-checking bench for fixed_mac_lanes with default parameters.
//            Expected results come from an integer model of the packet
//            dot product converted to the output fixed-point format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_mac_lanes;

    localparam int WI1 = 6, WF1 = 10, WI2 = 4, WF2 = 8, WIO = 15, WFO = 30;
    localparam int LANES = 4, GUARD = 8, SAT = 1, ROUND = 0;
    localparam int AW = WI1 + WF1;
    localparam int BW = WI2 + WF2;
    localparam int OW = WIO + WFO;
    localparam int FP = WF1 + WF2;

    typedef struct packed {
        logic          v;
        logic [OW-1:0] d;
        logic          ovf;
        logic          mis;
    } obs_t;

    typedef struct packed {
        logic [LANES*AW-1:0] a;
        logic [LANES*BW-1:0] b;
        logic                al;
        logic                bl;
    } bt_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [LANES*AW-1:0] A_data;
    logic                A_valid, A_ready, A_last;
    logic [LANES*BW-1:0] B_data;
    logic                B_valid, B_ready, B_last;
    logic [OW-1:0]       out_data;
    logic                out_valid, out_ready, out_ovf, out_mismatch;

    int     n_pass = 0;
    int     n_total = 0;
    obs_t   exp_q[$];
    longint pkt_sum = 0;

    always #5 clk = ~clk;

    fixed_mac_lanes #(
        .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2), .WIO(WIO), .WFO(WFO),
        .LANES(LANES), .GUARD(GUARD), .SAT(SAT), .ROUND(ROUND)
    ) dut (
        .clk(clk), .reset(reset),
        .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready), .A_last(A_last),
        .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready), .B_last(B_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ovf(out_ovf), .out_mismatch(out_mismatch)
    );

    // Exact dot product of one beat, in units of 2^-FP.
    function automatic longint dot(input logic [LANES*AW-1:0] ad, input logic [LANES*BW-1:0] bd);
        longint s;
        logic signed [AW-1:0] a;
        logic signed [BW-1:0] b;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            a = ad[i*AW +: AW];
            b = bd[i*BW +: BW];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    // Packet sum -> output format: rescale, then saturate or wrap.
    function automatic obs_t model(input longint s, input logic mis);
        obs_t   r;
        longint v, mx, mn;
        int     d;
        if (WFO >= FP) begin
            v = s * (longint'(1) <<< (WFO - FP));
        end else begin
            d = FP - WFO;
            if (ROUND != 0) v = (s + (longint'(1) <<< (d - 1))) >>> d;
            else            v = s >>> d;
        end
        mx = (longint'(1) <<< (OW - 1)) - 1;
        mn = -mx - 1;
        r.v   = 1'b1;
        r.mis = mis;
        r.ovf = (v > mx) || (v < mn);
        if (r.ovf && (SAT != 0)) r.d = (v > mx) ? mx[OW-1:0] : mn[OW-1:0];
        else                     r.d = v[OW-1:0];
        return r;
    endfunction

    function automatic logic [LANES*AW-1:0] rand_a();
        logic [LANES*AW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*AW +: AW] = AW'($urandom());
        return v;
    endfunction

    function automatic logic [LANES*BW-1:0] rand_b();
        logic [LANES*BW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*BW +: BW] = BW'($urandom());
        return v;
    endfunction

    // One clock: drive at negedge, observe 1ns later, update the model on an accepted beat.
    task automatic beat(input logic v, input logic [LANES*AW-1:0] ad, input logic [LANES*BW-1:0] bd,
                        input logic al, input logic bl, input logic ordy,
                        output obs_t ob, output logic rdy, output logic rdy_b, output logic fired);
        @(negedge clk);
        A_valid = v; B_valid = v; A_data = ad; B_data = bd;
        A_last = al; B_last = bl; out_ready = ordy;
        #1;
        ob.v = out_valid; ob.d = out_data; ob.ovf = out_ovf; ob.mis = out_mismatch;
        rdy = A_ready; rdy_b = B_ready;
        fired = v && A_ready;
        if (fired) begin
            pkt_sum += dot(ad, bd);
            if (al || bl) begin
                exp_q.push_back(model(pkt_sum, al ^ bl));
                pkt_sum = 0;
            end
        end
        @(posedge clk);
    endtask

    // Idle with out_ready high until a result is observed or the budget runs out.
    task automatic wait_result(output obs_t ob, output logic to);
        logic r, rb, f;
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ob, r, rb, f);
            if (ob.v) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        A_valid = 1'b0; B_valid = 1'b0; A_last = 1'b0; B_last = 1'b0;
        A_data = '0; B_data = '0; out_ready = 1'b0;
        reset = 1'b1; #1; reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 || out_mismatch !== 1'b0)
            $display("FAIL reset_outputs: valid=%0b data=%h ovf=%0b mis=%0b, required all 0",
                     out_valid, out_data, out_ovf, out_mismatch);
        else n_pass++;
        n_total++;
        if (A_ready !== 1'b0 || B_ready !== 1'b0)
            $display("FAIL reset_ready: A_ready=%0b B_ready=%0b, required 0 0", A_ready, B_ready);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (A_ready !== 1'b1 || B_ready !== 1'b1)
            $display("FAIL release_ready: A_ready=%0b B_ready=%0b, required 1 1", A_ready, B_ready);
        else n_pass++;
    endtask

    task automatic test_unity();
        obs_t ob;
        logic r, rb, f;
        exp_q.delete(); pkt_sum = 0;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, {LANES{16'h0400}}, {LANES{12'h100}}, i == 2, i == 2, 1'b1, ob, r, rb, f);
            n_total++;
            if (f !== 1'b1) $display("FAIL unity_accept: beat %0d fired=%0b, required 1", i, f);
            else n_pass++;
        end
        beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ob, r, rb, f);
        n_total++;
        if (ob.v !== 1'b0) $display("FAIL unity_latency_early: out_valid=%0b one edge after close, required 0", ob.v);
        else n_pass++;
        beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ob, r, rb, f);
        n_total++;
        if (ob.v !== 1'b1 || ob.d !== 45'h003_0000_0000 || ob.ovf !== 1'b0 || ob.mis !== 1'b0)
            $display("FAIL unity_result: valid=%0b data=%h ovf=%0b mis=%0b, required 1 003000000000 0 0",
                     ob.v, ob.d, ob.ovf, ob.mis);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_neg_one();
        obs_t ob;
        logic r, rb, f, to;
        exp_q.delete(); pkt_sum = 0;
        beat(1'b1, {48'h0, 16'hFC00}, {36'h0, 12'h100}, 1'b1, 1'b1, 1'b1, ob, r, rb, f);
        wait_result(ob, to);
        n_total++;
        if (to || ob.d !== 45'h1FFF_C000_0000 || ob.ovf !== 1'b0 || ob.mis !== 1'b0)
            $display("FAIL neg_one: timeout=%0b data=%h ovf=%0b mis=%0b, required 0 1fffc0000000 0 0",
                     to, ob.d, ob.ovf, ob.mis);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_saturate();
        obs_t ob;
        logic r, rb, f, to;
        int   cnt;
        exp_q.delete(); pkt_sum = 0; cnt = 0;
        for (int i = 0; i < 32; i++) begin
            beat(1'b1, {LANES{16'h7FFF}}, {LANES{12'h7FF}}, i == 31, i == 31, 1'b1, ob, r, rb, f);
            if (f) cnt++;
        end
        wait_result(ob, to);
        n_total++;
        if (to || ob.d !== 45'h0FFF_FFFF_FFFF || ob.ovf !== 1'b1)
            $display("FAIL sat_pos: timeout=%0b data=%h ovf=%0b, required 0 0fffffffffff 1", to, ob.d, ob.ovf);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            beat(1'b1, {LANES{16'h8000}}, {LANES{12'h7FF}}, i == 31, i == 31, 1'b1, ob, r, rb, f);
            if (f) cnt++;
        end
        wait_result(ob, to);
        n_total++;
        if (to || ob.d !== 45'h1000_0000_0000 || ob.ovf !== 1'b1)
            $display("FAIL sat_neg: timeout=%0b data=%h ovf=%0b, required 0 100000000000 1", to, ob.d, ob.ovf);
        else n_pass++;
        n_total++;
        if (cnt !== 64) $display("FAIL sat_accept: accepted %0d beats, required 64", cnt);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_mismatch();
        obs_t ob, ex;
        logic r, rb, f, to;
        exp_q.delete(); pkt_sum = 0;
        beat(1'b1, rand_a(), rand_b(), 1'b0, 1'b0, 1'b1, ob, r, rb, f);
        beat(1'b1, rand_a(), rand_b(), 1'b1, 1'b0, 1'b1, ob, r, rb, f);
        wait_result(ob, to);
        ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_total++;
        if (to || ob !== ex || ob.mis !== 1'b1)
            $display("FAIL mismatch_a_only: got v=%0b d=%h ovf=%0b mis=%0b, required v=1 d=%h ovf=%0b mis=1",
                     ob.v, ob.d, ob.ovf, ob.mis, ex.d, ex.ovf);
        else n_pass++;
        beat(1'b1, rand_a(), rand_b(), 1'b1, 1'b1, 1'b1, ob, r, rb, f);
        wait_result(ob, to);
        ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_total++;
        if (to || ob !== ex || ob.mis !== 1'b0)
            $display("FAIL mismatch_fresh_packet: got v=%0b d=%h ovf=%0b mis=%0b, required v=1 d=%h ovf=%0b mis=0",
                     ob.v, ob.d, ob.ovf, ob.mis, ex.d, ex.ovf);
        else n_pass++;
        beat(1'b1, rand_a(), rand_b(), 1'b0, 1'b1, 1'b1, ob, r, rb, f);
        wait_result(ob, to);
        ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_total++;
        if (to || ob !== ex || ob.mis !== 1'b1)
            $display("FAIL mismatch_b_only: got v=%0b d=%h ovf=%0b mis=%0b, required v=1 d=%h ovf=%0b mis=1",
                     ob.v, ob.d, ob.ovf, ob.mis, ex.d, ex.ovf);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bt_t  beats[$];
        bt_t  b;
        obs_t ob, prev, ex;
        logic r, rb, f, ordy, prev_stall, saw_low, split;
        int   idx, got, npkt, len, sel;
        exp_q.delete(); pkt_sum = 0; npkt = 12;
        for (int p = 0; p < npkt; p++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                b.a = rand_a(); b.b = rand_b(); b.al = 1'b0; b.bl = 1'b0;
                if (i == len - 1) begin
                    sel = $urandom_range(0, 7);
                    b.al = (sel != 1);
                    b.bl = (sel != 0);
                end
                beats.push_back(b);
            end
        end
        idx = 0; got = 0; prev = '0; prev_stall = 1'b0; saw_low = 1'b0; split = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < npkt; cyc++) begin
            ordy = (cyc >= 6 && cyc < 16) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (idx < beats.size())
                beat(1'b1, beats[idx].a, beats[idx].b, beats[idx].al, beats[idx].bl, ordy, ob, r, rb, f);
            else
                beat(1'b0, '0, '0, 1'b0, 1'b0, ordy, ob, r, rb, f);
            if (f) idx++;
            if (r !== rb) split = 1'b1;
            if (!r) saw_low = 1'b1;
            if (prev_stall) begin
                n_total++;
                if (ob !== prev)
                    $display("FAIL b2b_hold: cycle %0d got v=%0b d=%h ovf=%0b mis=%0b, required held v=%0b d=%h ovf=%0b mis=%0b",
                             cyc, ob.v, ob.d, ob.ovf, ob.mis, prev.v, prev.d, prev.ovf, prev.mis);
                else n_pass++;
            end
            if (ob.v && ordy) begin
                got++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_unexpected: result %0d d=%h with no packet outstanding, required none", got, ob.d);
                end else begin
                    ex = exp_q.pop_front();
                    if (ob !== ex)
                        $display("FAIL b2b_result: packet %0d got d=%h ovf=%0b mis=%0b, required d=%h ovf=%0b mis=%0b",
                                 got, ob.d, ob.ovf, ob.mis, ex.d, ex.ovf, ex.mis);
                    else n_pass++;
                end
            end
            prev = ob;
            prev_stall = ob.v && !ordy;
        end
        n_total++;
        if (got !== npkt || idx !== beats.size())
            $display("FAIL b2b_count: results=%0d beats=%0d, required %0d and %0d", got, idx, npkt, beats.size());
        else n_pass++;
        n_total++;
        if (saw_low !== 1'b1) $display("FAIL b2b_ready_drop: ready low seen=%0b, required 1", saw_low);
        else n_pass++;
        n_total++;
        if (split !== 1'b0) $display("FAIL b2b_ready_equal: A_ready/B_ready differed=%0b, required 0", split);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t ob, ex;
        logic r, rb, f, to;
        exp_q.delete(); pkt_sum = 0;
        beat(1'b1, rand_a(), rand_b(), 1'b1, 1'b1, 1'b0, ob, r, rb, f);
        beat(1'b1, rand_a(), rand_b(), 1'b0, 1'b0, 1'b0, ob, r, rb, f);
        beat(1'b1, rand_a(), rand_b(), 1'b0, 1'b0, 1'b0, ob, r, rb, f);
        n_total++;
        if (ob.v !== 1'b1) $display("FAIL midrst_pending: out_valid=%0b before reset, required 1", ob.v);
        else n_pass++;
        @(negedge clk);
        A_valid = 1'b0; B_valid = 1'b0; reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 || out_mismatch !== 1'b0)
            $display("FAIL midrst_outputs: valid=%0b data=%h ovf=%0b mis=%0b, required all 0",
                     out_valid, out_data, out_ovf, out_mismatch);
        else n_pass++;
        n_total++;
        if (A_ready !== 1'b0 || B_ready !== 1'b0)
            $display("FAIL midrst_ready: A_ready=%0b B_ready=%0b, required 0 0", A_ready, B_ready);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete(); pkt_sum = 0;
        beat(1'b1, rand_a(), rand_b(), 1'b1, 1'b1, 1'b1, ob, r, rb, f);
        wait_result(ob, to);
        ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_total++;
        if (!f || to || ob !== ex)
            $display("FAIL midrst_next_packet: fired=%0b timeout=%0b d=%h ovf=%0b mis=%0b, required 1 0 d=%h ovf=%0b mis=%0b",
                     f, to, ob.d, ob.ovf, ob.mis, ex.d, ex.ovf, ex.mis);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_unity();
        test_neg_one();
        test_saturate();
        test_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
